// File: rtl/keyboard_pkg.sv
// Shared scan-code constants, LED command layout and state encodings for the
// PS/2 key event sequencer.
package keyboard_pkg;

    localparam logic [7:0] SC_E0   = 8'hE0;
    localparam logic [7:0] SC_F0   = 8'hF0;
    localparam logic [7:0] SC_E1   = 8'hE1;
    localparam logic [7:0] SC_FA   = 8'hFA;
    localparam logic [7:0] SC_FE   = 8'hFE;
    localparam logic [7:0] SC_AA   = 8'hAA;
    localparam logic [7:0] SC_ED   = 8'hED;
    localparam logic [7:0] SC_CAPS = 8'h58;
    localparam logic [7:0] SC_NUL  = 8'h00;
    localparam logic [7:0] SC_ERR  = 8'hFF;

    localparam int LED_CAPS_BIT = 2;

    localparam logic [2:0] P_IDLE    = 3'd0;
    localparam logic [2:0] P_EXT     = 3'd1;
    localparam logic [2:0] P_REL     = 3'd2;
    localparam logic [2:0] P_EXT_REL = 3'd3;
    localparam logic [2:0] P_PAUSE   = 3'd4;

    localparam logic [2:0] L_IDLE = 3'd0;
    localparam logic [2:0] L_CMD  = 3'd1;
    localparam logic [2:0] L_ACK1 = 3'd2;
    localparam logic [2:0] L_LED  = 3'd3;
    localparam logic [2:0] L_ACK2 = 3'd4;

    function automatic logic [7:0] led_byte(input logic caps);
        led_byte = 8'h00;
        led_byte[LED_CAPS_BIT] = caps;
    endfunction

endpackage

// File: rtl/timeout_counter.sv
// Saturating down-counter: load arms it with CYCLES, expired flags the last
// tick cycle of an uninterrupted wait.
module timeout_counter #(
    parameter int CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic tick,
    output logic expired
);

    localparam int W = $clog2(CYCLES + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= W'(CYCLES);
        end else if (tick && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expired = tick && !load && (count <= W'(1));

endmodule

// File: rtl/key_event_sequencer.sv
// PS/2 scan-code decoder with prefix tracking, caps-lock handling and the
// keyboard LED update handshake.
//   state     | meaning
//   P_IDLE    | no prefix seen
//   P_EXT     | E0 seen
//   P_REL     | F0 seen
//   P_EXT_REL | E0 F0 seen
//   P_PAUSE   | skipping the rest of the E1 pause sequence
//   L_IDLE    | LED sequencer quiet
//   L_CMD     | offering ED to the transmitter
//   L_ACK1    | waiting for FA after ED
//   L_LED     | offering the LED byte
//   L_ACK2    | waiting for FA after LED byte
module key_event_sequencer
    import keyboard_pkg::*;
#(
    parameter int TIMEOUT_CYCLES     = 1000000,
    parameter int ACK_TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] message_out,
    output logic       message_latch,
    output logic       release_key,
    output logic       extended_code,
    output logic       caps_lock,
    output logic       kbd_error
);

    logic [2:0] pstate, lstate;
    logic [2:0] skip_cnt;
    logic [1:0] resend_cnt;
    logic       caps_held, pending;
    logic       pre_expired, ack_expired;
    logic       bad_byte, resp_byte, prefix_byte, emit, is_rel, is_ext;
    logic       caps_make, caps_break, trigger, in_ack;
    logic       err_prefix, err_led;

    timeout_counter #(.CYCLES(TIMEOUT_CYCLES)) u_prefix_timer (
        .clk(clk), .rst(rst), .load(rx_valid), .tick(pstate != P_IDLE),
        .expired(pre_expired)
    );

    timeout_counter #(.CYCLES(ACK_TIMEOUT_CYCLES)) u_ack_timer (
        .clk(clk), .rst(rst), .load(tx_valid), .tick(in_ack),
        .expired(ack_expired)
    );

    always_comb begin
        bad_byte    = rx_valid && (rx_data == SC_NUL || rx_data == SC_ERR);
        resp_byte   = (rx_data == SC_FA || rx_data == SC_FE || rx_data == SC_AA);
        prefix_byte = (pstate == P_IDLE && (rx_data == SC_E0 || rx_data == SC_F0 || rx_data == SC_E1))
                   || (pstate == P_EXT && rx_data == SC_F0);
        emit        = rx_valid && !bad_byte && pstate != P_PAUSE && !resp_byte && !prefix_byte;
        is_rel      = (pstate == P_REL || pstate == P_EXT_REL);
        is_ext      = (pstate == P_EXT || pstate == P_EXT_REL);
        caps_make   = emit && rx_data == SC_CAPS && !is_ext && !is_rel && !caps_held;
        caps_break  = emit && rx_data == SC_CAPS && !is_ext && is_rel;
        trigger     = caps_make || (rx_valid && rx_data == SC_AA);
        err_prefix  = bad_byte || (!rx_valid && pre_expired);
        tx_valid    = (lstate == L_CMD || lstate == L_LED);
        in_ack      = (lstate == L_ACK1 || lstate == L_ACK2);
        err_led     = in_ack && ((rx_valid && rx_data == SC_FE && resend_cnt == 2'd3)
                              || (!rx_valid && ack_expired));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pstate        <= P_IDLE;
            skip_cnt      <= '0;
            message_out   <= '0;
            message_latch <= 1'b0;
            release_key   <= 1'b0;
            extended_code <= 1'b0;
            caps_lock     <= 1'b0;
            caps_held     <= 1'b0;
            kbd_error     <= 1'b0;
        end else begin
            message_latch <= emit;
            kbd_error     <= err_prefix || err_led;
            if (emit) begin
                message_out   <= rx_data;
                release_key   <= is_rel;
                extended_code <= is_ext;
            end
            if (caps_make) begin
                caps_lock <= ~caps_lock;
                caps_held <= 1'b1;
            end else if (caps_break) begin
                caps_held <= 1'b0;
            end

            if (bad_byte) begin
                pstate <= P_IDLE;
            end else if (rx_valid) begin
                if (pstate == P_PAUSE) begin
                    if (skip_cnt <= 3'd1) begin
                        pstate   <= P_IDLE;
                        skip_cnt <= '0;
                    end else begin
                        skip_cnt <= skip_cnt - 3'd1;
                    end
                end else if (!resp_byte) begin
                    // Keyboard responses leave any half-received prefix intact.
                    if (pstate == P_IDLE && rx_data == SC_E0)      pstate <= P_EXT;
                    else if (pstate == P_IDLE && rx_data == SC_F0) pstate <= P_REL;
                    else if (pstate == P_EXT && rx_data == SC_F0)  pstate <= P_EXT_REL;
                    else if (pstate == P_IDLE && rx_data == SC_E1) begin
                        pstate   <= P_PAUSE;
                        skip_cnt <= 3'd7;
                    end else begin
                        pstate <= P_IDLE;
                    end
                end
            end else if (pre_expired) begin
                pstate <= P_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lstate     <= L_IDLE;
            tx_data    <= '0;
            resend_cnt <= '0;
            pending    <= 1'b0;
        end else begin
            if (trigger && lstate != L_IDLE) pending <= 1'b1;
            case (lstate)
                L_IDLE: begin
                    if (trigger || pending) begin
                        lstate     <= L_CMD;
                        tx_data    <= SC_ED;
                        resend_cnt <= '0;
                        pending    <= 1'b0;
                    end
                end
                L_CMD: if (tx_ready) lstate <= L_ACK1;
                L_LED: if (tx_ready) lstate <= L_ACK2;
                L_ACK1, L_ACK2: begin
                    if (rx_valid && rx_data == SC_FA) begin
                        if (lstate == L_ACK1) begin
                            lstate     <= L_LED;
                            tx_data    <= led_byte(caps_lock);
                            resend_cnt <= '0;
                        end else begin
                            lstate <= L_IDLE;
                        end
                    end else if (rx_valid && rx_data == SC_FE) begin
                        if (resend_cnt == 2'd3) begin
                            lstate <= L_IDLE;
                        end else begin
                            resend_cnt <= resend_cnt + 2'd1;
                            lstate     <= (lstate == L_ACK1) ? L_CMD : L_LED;
                        end
                    end else if (ack_expired) begin
                        lstate <= L_IDLE;
                    end
                end
                default: lstate <= L_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_event_sequencer.sv
// Directed bench for key_event_sequencer: scan decoding, caps/LED handshake,
// timeouts, resend limit, pause skipping and asynchronous reset.
module tb_key_event_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] message_out;
    logic       message_latch;
    logic       release_key;
    logic       extended_code;
    logic       caps_lock;
    logic       kbd_error;

    int checks = 0;
    int errors = 0;
    int emit_cnt = 0;
    int err_cnt = 0;
    int tx_cnt = 0;
    int e0, r0, t0;

    key_event_sequencer #(.TIMEOUT_CYCLES(100), .ACK_TIMEOUT_CYCLES(200)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .message_out(message_out), .message_latch(message_latch),
        .release_key(release_key), .extended_code(extended_code),
        .caps_lock(caps_lock), .kbd_error(kbd_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (message_latch) emit_cnt++;
        if (kbd_error) err_cnt++;
    end

    always @(posedge clk) begin
        if (tx_valid && tx_ready) tx_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_tx(input string tag);
        int n = 0;
        while (!tx_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, " valid"}, 32'(tx_valid), 32'd1);
    endtask

    task automatic tx_hs(input string tag, input logic [7:0] exp);
        wait_tx(tag);
        check({tag, " data"}, 32'(tx_data), 32'(exp));
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        check({tag, " drop"}, 32'(tx_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst latch", 32'(message_latch), 32'd0);
        check("rst msg", 32'(message_out), 32'd0);
        check("rst txv", 32'(tx_valid), 32'd0);
        check("rst caps", 32'(caps_lock), 32'd0);
        check("rst err", 32'(kbd_error), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // plain make code
        e0 = emit_cnt;
        send_byte(8'h1C);
        check("1C emits", 32'(emit_cnt - e0), 32'd1);
        check("1C msg", 32'(message_out), 32'h1C);
        check("1C rel", 32'(release_key), 32'd0);
        check("1C ext", 32'(extended_code), 32'd0);

        // extended break
        e0 = emit_cnt;
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        check("E0F075 emits", 32'(emit_cnt - e0), 32'd1);
        check("E0F075 msg", 32'(message_out), 32'h75);
        check("E0F075 rel", 32'(release_key), 32'd1);
        check("E0F075 ext", 32'(extended_code), 32'd1);

        // caps toggle, typematic repeat, break, LED handshake
        e0 = emit_cnt; r0 = err_cnt; t0 = tx_cnt;
        send_byte(8'h58);
        check("caps on", 32'(caps_lock), 32'd1);
        send_byte(8'h58);
        send_byte(8'hF0); send_byte(8'h58);
        check("caps repeat", 32'(caps_lock), 32'd1);
        check("caps break rel", 32'(release_key), 32'd1);
        tx_hs("led cmd", 8'hED);
        send_byte(8'hFA);
        tx_hs("led byte", 8'h04);
        send_byte(8'hFA);
        repeat (5) @(negedge clk);
        check("led idle txv", 32'(tx_valid), 32'd0);
        check("caps emits", 32'(emit_cnt - e0), 32'd3);
        check("caps tx count", 32'(tx_cnt - t0), 32'd2);
        check("caps no err", 32'(err_cnt - r0), 32'd0);

        // prefix timeout
        r0 = err_cnt;
        send_byte(8'hE0);
        repeat (110) @(negedge clk);
        check("timeout err", 32'(err_cnt - r0), 32'd1);
        send_byte(8'h1C);
        check("post-timeout msg", 32'(message_out), 32'h1C);
        check("post-timeout ext", 32'(extended_code), 32'd0);

        // resend limit in L_ACK1
        r0 = err_cnt; t0 = tx_cnt; e0 = emit_cnt;
        send_byte(8'hAA);
        tx_hs("aa cmd", 8'hED);
        for (int i = 0; i < 4; i++) begin
            send_byte(8'hFE);
            if (i < 3) tx_hs("resend", 8'hED);
        end
        repeat (3) @(negedge clk);
        check("resend tx count", 32'(tx_cnt - t0), 32'd4);
        check("resend err", 32'(err_cnt - r0), 32'd1);
        check("resend idle txv", 32'(tx_valid), 32'd0);
        check("resp no emit", 32'(emit_cnt - e0), 32'd0);

        // acknowledge timeout
        r0 = err_cnt;
        send_byte(8'hAA);
        tx_hs("ackto cmd", 8'hED);
        repeat (220) @(negedge clk);
        check("ack timeout err", 32'(err_cnt - r0), 32'd1);
        check("ack timeout txv", 32'(tx_valid), 32'd0);

        // trigger while busy restarts once
        t0 = tx_cnt;
        send_byte(8'hAA); send_byte(8'hAA);
        tx_hs("pend cmd1", 8'hED); send_byte(8'hFA);
        tx_hs("pend led1", 8'h04); send_byte(8'hFA);
        tx_hs("pend cmd2", 8'hED); send_byte(8'hFA);
        tx_hs("pend led2", 8'h04); send_byte(8'hFA);
        repeat (5) @(negedge clk);
        check("pend tx count", 32'(tx_cnt - t0), 32'd4);
        check("pend idle txv", 32'(tx_valid), 32'd0);

        // pause sequence is swallowed
        e0 = emit_cnt; r0 = err_cnt;
        send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
        send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
        check("pause emits", 32'(emit_cnt - e0), 32'd0);
        check("pause err", 32'(err_cnt - r0), 32'd0);
        send_byte(8'h1C);
        check("post-pause emit", 32'(emit_cnt - e0), 32'd1);

        // 00 is dropped, flags error and clears prefix
        e0 = emit_cnt; r0 = err_cnt;
        send_byte(8'hE0); send_byte(8'h00); send_byte(8'h75);
        check("nul err", 32'(err_cnt - r0), 32'd1);
        check("nul emits", 32'(emit_cnt - e0), 32'd1);
        check("nul ext", 32'(extended_code), 32'd0);
        check("nul msg", 32'(message_out), 32'h75);

        // asynchronous reset mid-L_LED
        send_byte(8'hAA);
        tx_hs("rst cmd", 8'hED);
        send_byte(8'hFA);
        wait_tx("rst led");
        check("pre-rst caps", 32'(caps_lock), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async txv", 32'(tx_valid), 32'd0);
        check("async caps", 32'(caps_lock), 32'd0);
        check("async txd", 32'(tx_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_event_sequencer.md
KEY_EVENT_SEQUENCER -- requirements
Module: key_event_sequencer

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000, meaning the maximum idle cycles allowed between bytes of one multi-byte scan sequence.
REQ-002 The block SHALL have parameter ACK_TIMEOUT_CYCLES, default 1000000, meaning the maximum cycles to wait for a keyboard acknowledge.
REQ-003 Ports SHALL be: clk  in  1  sole clock, all logic on rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 rx_data  in  8  received PS/2 byte; rx_valid  in  1  one-cycle strobe qualifying rx_data.
REQ-006 tx_data  out  8  byte to transmit to keyboard; tx_valid  out  1  transmit request; tx_ready  in  1  transmitter accepts.
REQ-007 message_out  out  8  final scan code; message_latch  out  1  one-cycle strobe; release_key  out  1  break flag; extended_code  out  1  E0 flag.
REQ-008 caps_lock  out  1  current caps state; kbd_error  out  1  one-cycle error strobe.

Function
REQ-009 Prefix FSM states SHALL be IDLE, EXT, REL, EXT_REL, PAUSE.
REQ-010 Transitions on rx_valid: IDLE+E0->EXT; IDLE+F0->REL; EXT+F0->EXT_REL; IDLE+E1->PAUSE with skip count 7; any other byte emits an event and returns to IDLE.
REQ-011 PAUSE SHALL consume 7 further bytes silently, then return to IDLE, emitting nothing.
REQ-012 Emit: the cycle after rx_valid, message_out=rx_data, release_key=1 if state was REL/EXT_REL, extended_code=1 if EXT/EXT_REL, message_latch high exactly one cycle.
REQ-013 message_out, release_key and extended_code SHALL hold until the next emit.
REQ-014 Bytes FA (ACK) and FE (resend) SHALL be consumed by the LED sequencer, never emitted; AA (self-test pass) SHALL be consumed, and it restarts the LED sequence to restore caps state.
REQ-015 Bytes 00 and FF SHALL be dropped, pulse kbd_error, and force the prefix FSM to IDLE.
REQ-016 In EXT, REL, EXT_REL or PAUSE, if TIMEOUT_CYCLES elapse without rx_valid: go to IDLE, pulse kbd_error.
REQ-017 If rx_valid and a timeout occur in the same cycle, rx_valid SHALL win.
REQ-018 Caps toggle: a non-extended make of 58 with caps_held=0 SHALL toggle caps_lock and set caps_held; a break of 58 clears caps_held; typematic repeats do not toggle.
REQ-019 LED FSM states SHALL be L_IDLE, L_CMD, L_ACK1, L_LED, L_ACK2.
REQ-020 LED FSM sequence: toggle or AA -> L_CMD sends ED -> L_ACK1 waits FA -> L_LED sends {5'b0, caps_lock, 2'b0} -> L_ACK2 waits FA -> L_IDLE.
REQ-021 In L_CMD/L_LED, tx_valid SHALL stay high with tx_data stable until the cycle tx_ready=1, then drop the next cycle.
REQ-022 FE in L_ACK1/L_ACK2 SHALL resend the preceding byte; at most 3 resends, then abort to L_IDLE with kbd_error.
REQ-023 No FA within ACK_TIMEOUT_CYCLES SHALL abort to L_IDLE and pulse kbd_error.
REQ-024 A trigger while not in L_IDLE SHALL set a pending flag; on return to L_IDLE the sequence restarts once using the current caps_lock.
REQ-025 Counters SHALL saturate, never wrap.

Reset
REQ-026 On rst: both FSMs idle, all outputs 0, caps_lock=0, caps_held=0, pending=0, counters 0, effective immediately without clk.

Structure
REQ-027 Package keyboard_pkg SHALL hold the scan constants E0, F0, E1, FA, FE, AA, ED, 58, the LED caps bit index, and both FSM state encodings.
REQ-028 One sub-module, timeout_counter (load, tick, expired), SHALL be instantiated twice.

Verification
REQ-029 Bytes 1C -> message_latch pulse, message_out=1C, release_key=0, extended_code=0.
REQ-030 Bytes E0,F0,75 -> one emit 75, release_key=1, extended_code=1; no emit for the prefixes.
REQ-031 Bytes 58, 58, F0,58 -> caps_lock=1 once; tx ED, FA, tx 04, FA -> L_IDLE.
REQ-032 Bytes E0 then silence for TIMEOUT_CYCLES (set 100) -> kbd_error pulse; next byte 1C emits as non-extended.
REQ-033 During L_ACK1: FE x4 -> ED sent 4 times total, then kbd_error, L_IDLE.
REQ-034 E1 plus 7 bytes -> no emit; rst asserted mid-L_LED -> tx_valid=0 and caps_lock=0 immediately.
